// File: rtl/cirno9_test_monitor.sv
// rtl/cirno9_test_monitor.sv - end-of-test monitor: tohost hit detection, timeout, run counters
module cirno9_test_monitor #(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter int              N_EVT       = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h8000003c),
    parameter int              HIT_TARGET  = 3,
    parameter int              TIMEOUT_CYC = 2500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear,
    input  logic [XLEN-1:0]        pc,
    input  logic                   pc_vld,
    input  logic                   retire,
    input  logic [N_EVT-1:0]       evt,
    input  logic [XLEN-1:0]        result_val,
    output logic [2:0]             state,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       inst_cnt,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [N_EVT*CNT_W-1:0] evt_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } state_t;

    // Comparisons against the integer limits are done in a width wide enough
    // for both sides, so a narrow CNT_W can never alias onto a truncated limit.
    localparam int CMP_W = (CNT_W > 32) ? CNT_W + 1 : 33;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_done, r_pass, r_fail, r_timeout;
    logic             w_next_done, w_next_pass, w_next_fail, w_next_timeout;
    logic [CNT_W-1:0] r_cycle_cnt, r_inst_cnt, r_hit_cnt;
    logic [CNT_W-1:0] r_evt_cnt [N_EVT];

    logic             w_run;
    logic             w_hit;
    logic             w_complete;
    logic             w_tmo;
    logic [CMP_W-1:0] w_hit_after;
    logic [CMP_W-1:0] w_cycle_ext;

    assign w_run       = (r_state == ST_RUN);
    assign w_hit       = pc_vld && (pc == TOHOST_ADDR);
    assign w_hit_after = CMP_W'(r_hit_cnt) + CMP_W'(1);
    assign w_cycle_ext = CMP_W'(r_cycle_cnt);
    // A saturated hit counter cannot advance, so it cannot complete the test.
    assign w_complete  = w_run && w_hit && (r_hit_cnt != '1)
                         && (w_hit_after == CMP_W'(HIT_TARGET));
    assign w_tmo       = w_run && (w_cycle_ext == CMP_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic: clear beats everything, a completing hit beats timeout
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_next_state = ST_RUN;
                ST_RUN: begin
                    if (w_complete)
                        w_next_state = (result_val == XLEN'(1)) ? ST_PASS : ST_FAIL;
                    else if (w_tmo)
                        w_next_state = ST_TMO;
                end
                ST_PASS, ST_FAIL, ST_TMO: w_next_state = r_state;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state, so the status flops track the state flop
    always_comb begin
        w_next_done    = (w_next_state == ST_PASS) || (w_next_state == ST_FAIL)
                         || (w_next_state == ST_TMO);
        w_next_pass    = (w_next_state == ST_PASS);
        w_next_fail    = (w_next_state == ST_FAIL) || (w_next_state == ST_TMO);
        w_next_timeout = (w_next_state == ST_TMO);
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= w_next_done;
            r_pass    <= w_next_pass;
            r_fail    <= w_next_fail;
            r_timeout <= w_next_timeout;
        end
    end

    // Saturating run counters; frozen outside RUN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
            r_hit_cnt   <= '0;
        end else if (w_run) begin
            if (r_cycle_cnt != '1)           r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (retire && r_inst_cnt != '1)  r_inst_cnt  <= r_inst_cnt + 1'b1;
            if (w_hit && r_hit_cnt != '1)    r_hit_cnt   <= r_hit_cnt + 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_EVT; k++) begin : g_evt
            // Saturating per-channel event counter
            always_ff @(posedge clk) begin
                if (rst || clear)
                    r_evt_cnt[k] <= '0;
                else if (w_run && evt[k] && r_evt_cnt[k] != '1)
                    r_evt_cnt[k] <= r_evt_cnt[k] + 1'b1;
            end
            assign evt_cnt[k*CNT_W +: CNT_W] = r_evt_cnt[k];
        end
    endgenerate

    assign state     = r_state;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign timeout   = r_timeout;
    assign cycle_cnt = r_cycle_cnt;
    assign inst_cnt  = r_inst_cnt;
    assign hit_cnt   = r_hit_cnt;

endmodule

// File: doc/cirno9_test_monitor.md
CIRNO9_TEST_MONITOR -- requirements
Module: cirno9_test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width.
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter.
REQ-003 SHALL have parameter N_EVT, default 4, number of generic event counters (1..16).
REQ-004 SHALL have parameter TOHOST_ADDR, default 32'h8000003c, end-of-test PC.
REQ-005 SHALL have parameter HIT_TARGET, default 3, tohost hits required to end the test (>=1).
REQ-006 SHALL have parameter TIMEOUT_CYC, default 2500, run-cycle limit (>=2).
REQ-007 SHALL have ports, one per line:
  clk  in  1  single clock, all logic on rising edge;
  rst  in  1  reset, synchronous, active-high;
  start  in  1  pulse, IDLE->RUN;
  clear  in  1  pulse, terminal/any state -> IDLE, zero counters;
  pc  in  XLEN  core PC;
  pc_vld  in  1  pc qualifier;
  retire  in  1  one instruction retired this cycle;
  evt  in  N_EVT  per-channel event strobes;
  result_val  in  XLEN  test result register (t3, x28);
  state  out  3  FSM state encoding;
  done  out  1  high in PASS, FAIL or TMO;
  pass  out  1  high in PASS only;
  fail  out  1  high in FAIL or TMO;
  timeout  out  1  high in TMO only;
  cycle_cnt  out  CNT_W  run cycles;
  inst_cnt  out  CNT_W  retired instructions;
  hit_cnt  out  CNT_W  tohost hits;
  evt_cnt  out  N_EVT*CNT_W  event counts, channel k at bits [k*CNT_W +: CNT_W].

Function
REQ-008 SHALL implement states IDLE=0, RUN=1, PASS=2, FAIL=3, TMO=4; state output equals the encoding.
REQ-009 SHALL move IDLE->RUN on the cycle after start=1; start in any other state SHALL be ignored.
REQ-010 SHALL, in RUN only, increment cycle_cnt by 1 every cycle, inst_cnt when retire=1, evt_cnt[k] when evt[k]=1, hit_cnt when pc_vld=1 and pc==TOHOST_ADDR.
REQ-011 SHALL saturate every counter at all-ones; no wrap-around.
REQ-012 SHALL hold all counters frozen outside RUN; events in IDLE, PASS, FAIL and TMO SHALL not count.
REQ-013 SHALL, when a RUN-cycle hit brings hit_cnt to HIT_TARGET, enter PASS next cycle if result_val==1 in that same cycle, else FAIL; the counters SHALL include that final cycle's increments.
REQ-014 SHALL enter TMO next cycle when in RUN with cycle_cnt==TIMEOUT_CYC-1 and no completing hit that cycle.
REQ-015 SHALL give a completing hit priority over timeout in the same cycle.
REQ-016 SHALL hold PASS, FAIL and TMO until clear or rst.
REQ-017 SHALL, on clear=1 in any state, enter IDLE next cycle and zero all counters; clear SHALL take priority over start and over all RUN transitions.
REQ-018 SHALL register done/pass/fail/timeout as direct state decodes; no combinational path from inputs to outputs.
REQ-019 SHALL compare pc and result_val at full XLEN width, with no X-propagation dependence.

Reset
REQ-020 SHALL, on the rising edge with rst=1, enter IDLE and zero cycle_cnt, inst_cnt, hit_cnt and every evt_cnt; done, pass, fail and timeout SHALL be 0.
REQ-021 SHALL give rst priority over clear, start and all state transitions, including mid-RUN.
REQ-022 SHALL not count during the reset cycle.

Verification
REQ-023 SHALL pass the following: start; 10 cycles retire=1; pc=TOHOST_ADDR 3 cycles with result_val=1 -> PASS, pass=1, hit_cnt=3, inst_cnt>=10, counts frozen afterwards.
REQ-024 SHALL pass the following: same as REQ-023 with result_val=5 on the third hit -> FAIL, fail=1, pass=0, timeout=0.
REQ-025 SHALL pass the following: TIMEOUT_CYC=20, start, never hit -> TMO one cycle after cycle_cnt=19; cycle_cnt=20, timeout=1, fail=1.
REQ-026 SHALL pass the following: TIMEOUT_CYC=20 with the third hit exactly in the cycle where cycle_cnt=19 and result_val=1 -> PASS, not TMO.
REQ-027 SHALL pass the following: CNT_W=4, evt[2] held high 20 RUN cycles -> evt_cnt ch2=15, the other channels 0.
REQ-028 SHALL pass the following: rst=1 mid-RUN after 7 cycles -> next cycle state=IDLE and all counters 0; start plus clear in the same cycle from IDLE -> stays IDLE.
